// File: rtl/mem_access_unit_pkg.sv
// Shared CPU package: load/store size encodings, access FSM states
// and the access legality check.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_MERGE,
        ST_WR,
        ST_DONE
    } state_t;

    // Misalignment, unsigned stores and unused encodings are all errors.
    function automatic logic access_err(
        input logic       we,
        input logic [2:0] f3,
        input logic [1:0] lane
    );
        logic e;
        e = 1'b0;
        case (f3)
            F3_B:    e = 1'b0;
            F3_H:    e = lane[0];
            F3_W:    e = (lane != 2'b00);
            F3_BU:   e = we;
            F3_HU:   e = we | lane[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte/half lane handling: store merge into a read word and
// load extraction with sign or zero extension.
module lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_lane, 3'b000} +: 8];
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_merged = i_word;
        case (i_funct3)
            F3_B: o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            F3_H: begin
                if (i_lane[1])
                    o_merged[31:16] = i_wdata[15:0];
                else
                    o_merged[15:0] = i_wdata[15:0];
            end
            default: o_merged = i_word;
        endcase
    end

    always_comb begin
        o_load = i_word;
        case (i_funct3)
            F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load = {24'h000000, w_byte};
            F3_H:    o_load = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load = {16'h0000, w_half};
            default: o_load = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit for a word-only memory: sub-word stores are done
// as read-modify-write, loads are lane-selected and extended.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       mem_wdata,
    output logic              mem_we
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        w_err_in;
    logic [31:0] w_merged;
    logic [31:0] w_load;

    assign w_err_in = access_err(we, funct3, addr[1:0]);

    lane_align u_lane_align (
        .i_funct3 (r_funct3),
        .i_lane   (r_addr[1:0]),
        .i_word   (mem_rdata),
        .i_wdata  (r_wdata),
        .o_merged (w_merged),
        .o_load   (w_load)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (w_err_in)
                        w_next = ST_DONE;
                    else if (we && funct3 == F3_W)
                        w_next = ST_WR;
                    else
                        w_next = ST_RD;
                end
            end
            ST_RD:    w_next = ST_MERGE;
            ST_MERGE: w_next = r_we ? ST_WR : ST_DONE;
            ST_WR:    w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && req) begin
                r_addr   <= addr;
                r_we     <= we;
                r_funct3 <= funct3;
                r_wdata  <= wdata;
                r_err    <= w_err_in;
            end
            // Store path reuses r_wdata to hold the merged word for WR.
            if (r_state == ST_MERGE) begin
                if (r_we)
                    r_wdata <= w_merged;
                else
                    r_rdata <= w_load;
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign err       = done & r_err;
    assign rdata     = r_rdata;
    assign mem_addr  = r_addr[ADDR_W+1:2];
    assign mem_wdata = r_wdata;
    assign mem_we    = (r_state == ST_WR) & ~rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic        mem_we;

    logic [31:0] mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we)
    );

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    end

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        int          wes;
        logic [31:0] rdata;
        int          idx;
        logic [31:0] word;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Starts at a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic do_access(input logic w, input logic [2:0] f,
                             input logic [31:0] a, input logic [31:0] d,
                             output int lat, output logic e,
                             output int wes);
        lat = 0;
        e   = 1'b0;
        wes = 0;
        we = w; funct3 = f; addr = a; wdata = d; req = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            req = 1'b0;
            if (mem_we) wes++;
            if (done) begin
                lat = k;
                e   = err;
                break;
            end
        end
        @(negedge clk);
    endtask

    function automatic vec_t mk(string nm, logic w, logic [2:0] f,
                                logic [31:0] a, logic [31:0] d, int l,
                                logic e, int ws, logic [31:0] rd, int ix,
                                logic [31:0] wd);
        vec_t v;
        v.name = nm; v.we = w; v.f3 = f; v.addr = a; v.wdata = d;
        v.lat = l; v.err = e; v.wes = ws; v.rdata = rd;
        v.idx = ix; v.word = wd;
        return v;
    endfunction

    initial begin
        int          lat;
        logic        e;
        int          wes;
        int          dn;
        string       nm;

        vecs[0]  = mk("sb100", 1, 3'b000, 32'h100, 32'h112233AA, 4, 0, 1,
                      32'h0, 64, 32'h000000AA);
        vecs[1]  = mk("sb101", 1, 3'b000, 32'h101, 32'h112233BB, 4, 0, 1,
                      32'h0, 64, 32'h0000BBAA);
        vecs[2]  = mk("sh102", 1, 3'b001, 32'h102, 32'h1122DDEE, 4, 0, 1,
                      32'h0, 64, 32'hDDEEBBAA);
        vecs[3]  = mk("sw104", 1, 3'b010, 32'h104, 32'hDEADBEEF, 2, 0, 1,
                      32'h0, 65, 32'hDEADBEEF);
        vecs[4]  = mk("lb103", 0, 3'b000, 32'h103, 32'h0, 3, 0, 0,
                      32'hFFFFFFDD, 64, 32'hDDEEBBAA);
        vecs[5]  = mk("lbu100", 0, 3'b100, 32'h100, 32'h0, 3, 0, 0,
                      32'h000000AA, 64, 32'hDDEEBBAA);
        vecs[6]  = mk("lh102", 0, 3'b001, 32'h102, 32'h0, 3, 0, 0,
                      32'hFFFFDDEE, 64, 32'hDDEEBBAA);
        vecs[7]  = mk("lhu102", 0, 3'b101, 32'h102, 32'h0, 3, 0, 0,
                      32'h0000DDEE, 64, 32'hDDEEBBAA);
        vecs[8]  = mk("sw106err", 1, 3'b010, 32'h106, 32'h12345678, 1, 1, 0,
                      32'h0000DDEE, 65, 32'hDEADBEEF);
        vecs[9]  = mk("lh101err", 0, 3'b001, 32'h101, 32'h0, 1, 1, 0,
                      32'h0000DDEE, 64, 32'hDDEEBBAA);
        vecs[10] = mk("lw104", 0, 3'b010, 32'h104, 32'h0, 3, 0, 0,
                      32'hDEADBEEF, 65, 32'hDEADBEEF);
        vecs[11] = mk("sbu_err", 1, 3'b100, 32'h100, 32'h99, 1, 1, 0,
                      32'hDEADBEEF, 64, 32'hDDEEBBAA);
        vecs[12] = mk("f3_011err", 0, 3'b011, 32'h100, 32'h0, 1, 1, 0,
                      32'hDEADBEEF, 64, 32'hDDEEBBAA);

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
        rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", {22'b0, mem_addr}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            do_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                      lat, e, wes);
            nm = vecs[i].name;
            chk({nm, "_lat"}, lat, vecs[i].lat);
            chk({nm, "_err"}, {31'b0, e}, {31'b0, vecs[i].err});
            chk({nm, "_we_pulses"}, wes, vecs[i].wes);
            chk({nm, "_rdata"}, rdata, vecs[i].rdata);
            chk({nm, "_word"}, mem[vecs[i].idx], vecs[i].word);
        end

        // req re-pulsed while busy and held into DONE must not queue.
        dn = 0;
        we = 1'b0; funct3 = 3'b010; addr = 32'h100; wdata = 32'h0;
        req = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) dn++;
            if (done || k > 3) req = 1'b0;
            else req = ~req | (k == 1);
        end
        chk("busy_req_dones", dn, 1);
        chk("busy_req_idle", {31'b0, busy}, 32'h0);
        chk("busy_req_rdata", rdata, 32'hDDEEBBAA);

        // Reset in the RD cycle of a byte store aborts without writing.
        wes = 0;
        we = 1'b1; funct3 = 3'b000; addr = 32'h100; wdata = 32'h77;
        req = 1'b1;
        @(posedge clk);
        req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_mem_we", {31'b0, mem_we}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_we) wes++;
            if (done) wes += 100;
        end
        chk("abort_no_activity", wes, 0);
        chk("abort_word", mem[64], 32'hDDEEBBAA);
        chk("abort_rdata", rdata, 32'h0);

        do_access(1'b1, 3'b000, 32'h100, 32'h00000055, lat, e, wes);
        chk("post_rst_sb_lat", lat, 4);
        chk("post_rst_sb_err", {31'b0, e}, 32'h0);
        chk("post_rst_sb_we", wes, 1);
        chk("post_rst_sb_word", mem[64], 32'hDDEEBB55);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
